// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell stepped over WIDTH cycles, LSB first, with start/done handshake.
// Optional macro SERIAL_SUBTRACT_EN adds a sub input that turns the operation into A - B.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_shift;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             carry;
  logic             fa_sum;
  logic             fa_cout;
  logic             load;
  logic             last;
  logic [CW-1:0]    cnt;

  // The single full-adder cell shared by every bit step.
  assign fa_sum  = a_sr[0] ^ b_sr[0] ^ carry;
  assign fa_cout = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
  assign last    = (cnt == CW'(WIDTH - 1));

  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_shift = fa_sum;
    end else begin : g_wn
      assign sum_shift = {fa_sum, sum_sr[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
`ifdef SERIAL_SUBTRACT_EN
    b_load = sub ? ~b : b;
    c_load = sub ? 1'b1 : cin;
`else
    b_load = b;
    c_load = cin;
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (last) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        ready = 1'b1;
        done  = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: all datapath flops are reset, so an aborted operation leaves no stale result behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      res    <= '0;
      cout   <= 1'b0;
    end else if (load) begin
      a_sr  <= a;
      b_sr  <= b_load;
      carry <= c_load;
      cnt   <= '0;
    end else if (busy) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      sum_sr <= sum_shift;
      carry  <= fa_cout;
      cnt    <= cnt + CW'(1);
      // The result registers change only on the final step, so they hold through RUN.
      if (last) begin
        res  <= sum_shift;
        cout <= fa_cout;
      end
    end
  end

endmodule
